// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - request and instruction-memory write bus of instr_encoder
//
// Purpose : bundles the request handshake (req_*) and the instruction-memory
//           write handshake (imem_*) into one interface.
// Modports:
//   slave  - the encoder: consumes req_*, drives req_ready and imem_we/addr/wdata,
//            consumes imem_ready.
//   master - the environment: drives req_* and imem_ready, observes the rest.
interface instr_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [5:0]        req_opcode;
  logic [4:0]        req_ra;
  logic [4:0]        req_rb;
  logic [4:0]        req_rc;
  logic [25:0]       req_imm;
  logic              req_last;
  logic              imem_we;
  logic              imem_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport slave (
    input  req_valid, req_opcode, req_ra, req_rb, req_rc, req_imm, req_last, imem_ready,
    output req_ready, imem_we, imem_addr, imem_wdata
  );

  modport master (
    output req_valid, req_opcode, req_ra, req_rb, req_rc, req_imm, req_last, imem_ready,
    input  req_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - encodes instruction requests and streams them into instruction memory
//
// Purpose : turns decoded requests (opcode + register/immediate fields) into
//           32-bit instruction words, buffers them in a DEPTH-entry FIFO and
//           writes them to consecutive word addresses starting at base_addr.
// Ports   :
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   start          begin a session at base_addr (honoured in IDLE only)
//   base_addr      first word address of the session
//   bus            request handshake in, memory write handshake out
//   busy           session in progress
//   done           one-cycle pulse after the last word is written
//   wr_count       words written this session
//   err_illegal    sticky: illegal opcode accepted (cleared by start)
//   err_wrap       sticky: write address wrapped to 0 (cleared by start)
module instr_encoder #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  instr_encoder_if.slave    bus,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   wr_count,
  output logic              err_illegal,
  output logic              err_wrap
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [31:0]       mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  logic [ADDR_W-1:0] addr_q;
  logic              empty, full;
  logic              accept, push, pop;
  logic              legal;
  logic [31:0]       enc_word;

  assign empty = (count == '0);
  assign full  = (count == (PTR_W+1)'(DEPTH));

  // Opcode map shared with the decode-stage control unit.
  always_comb begin
    legal    = 1'b1;
    enc_word = {bus.req_opcode, 26'd0};
    case (bus.req_opcode)
      6'h00, 6'h01, 6'h02:
        enc_word[25:0] = {bus.req_ra, bus.req_rb, bus.req_rc, 11'd0};
      6'h10, 6'h11, 6'h12, 6'h13, 6'h30:
        enc_word[25:0] = {bus.req_ra, bus.req_rb, bus.req_imm[15:0]};
      6'h31:
        enc_word[25:0] = bus.req_imm;
      default:
        legal = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt      = state;
    bus.req_ready  = 1'b0;
    bus.imem_we    = 1'b0;
    bus.imem_wdata = '0;
    busy           = (state != IDLE);
    done           = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = STREAM;
      end
      STREAM: begin
        bus.req_ready = !full;
        bus.imem_we   = !empty;
        if (bus.req_valid && !full && bus.req_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        bus.imem_we = !empty;
        if (empty) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Head of FIFO is only presented while a write is offered, so it reads 0 otherwise.
    if (bus.imem_we) bus.imem_wdata = mem[rd_ptr];
  end

  assign accept        = bus.req_valid && bus.req_ready;
  // Illegal requests complete their handshake but never enter the FIFO.
  assign push          = accept && legal;
  assign pop           = bus.imem_we && bus.imem_ready;
  assign bus.imem_addr = addr_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= enc_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      addr_q      <= '0;
      wr_count    <= '0;
      err_illegal <= 1'b0;
      err_wrap    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (state == IDLE && start) begin
        addr_q      <= base_addr;
        wr_count    <= '0;
        err_illegal <= 1'b0;
        err_wrap    <= 1'b0;
      end else begin
        if (pop) begin
          addr_q   <= addr_q + 1'b1;
          wr_count <= wr_count + 1'b1;
          if (addr_q == '1) err_wrap <= 1'b1;
        end
        if (accept && !legal) err_illegal <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - self-checking bench for instr_encoder
module tb_instr_encoder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] base_addr = '0;
  logic       busy, done, err_illegal, err_wrap;
  logic [8:0] wr_count;

  instr_encoder_if #(.ADDR_W(8)) bus ();

  instr_encoder #(.ADDR_W(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .bus(bus),
    .busy(busy), .done(done), .wr_count(wr_count),
    .err_illegal(err_illegal), .err_wrap(err_wrap)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference encoding computed from field positions with plain arithmetic.
  function automatic logic [31:0] model_enc(int op, int ra, int rb, int rc, int imm);
    longint w;
    w = longint'(op) * 64'd67108864;                        // op * 2^26
    if (op <= 2)
      w += longint'(ra) * 2097152 + longint'(rb) * 65536 + longint'(rc) * 2048;
    else if (op == 49)
      w += longint'(imm) % 67108864;
    else
      w += longint'(ra) * 2097152 + longint'(rb) * 65536 + longint'(imm) % 65536;
    return w[31:0];
  endfunction

  function automatic bit model_legal(int op);
    return op inside {0, 1, 2, 16, 17, 18, 19, 48, 49};
  endfunction

  // Model state
  logic [7:0]  exp_addr[$];
  logic [31:0] exp_data[$];
  int          m_addr = 0;
  int          m_cnt = 0;
  bit          m_sess = 0, m_ill = 0, m_wrap = 0;
  bit          prev_stall = 0, prev_done = 0;
  logic [7:0]  prev_addr;
  logic [31:0] prev_data;
  int          done_cnt = 0;
  logic [7:0]  log_addr[16];
  logic [31:0] log_data[16];
  int          log_n = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_outputs", {bus.req_ready, bus.imem_we, busy, done, err_illegal, err_wrap}, 0);
      chk("rst_addr", bus.imem_addr, 0);
      chk("rst_wdata", bus.imem_wdata, 0);
      chk("rst_wr_count", wr_count, 0);
      exp_addr.delete(); exp_data.delete();
      m_addr = 0; m_cnt = 0; m_sess = 0; m_ill = 0; m_wrap = 0;
      prev_stall = 0; prev_done = 0;
    end else begin
      chk("busy", busy, m_sess);
      chk("wr_count", wr_count, m_cnt);
      chk("err_illegal", err_illegal, m_ill);
      chk("err_wrap", err_wrap, m_wrap);
      if (prev_stall) begin
        chk("hold_we", bus.imem_we, 1);
        chk("hold_addr", bus.imem_addr, prev_addr);
        chk("hold_data", bus.imem_wdata, prev_data);
      end
      if (done) begin
        chk("done_width", prev_done, 0);
        chk("done_drained", exp_addr.size(), 0);
        done_cnt++;
      end
      if (bus.imem_we && bus.imem_ready) begin
        if (exp_addr.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          logic [7:0]  ea;
          logic [31:0] ed;
          ea = exp_addr.pop_front();
          ed = exp_data.pop_front();
          chk("write_addr", bus.imem_addr, ea);
          chk("write_data", bus.imem_wdata, ed);
          if (ea == 8'hFF) m_wrap = 1;
          if (log_n < 16) begin
            log_addr[log_n] = bus.imem_addr;
            log_data[log_n] = bus.imem_wdata;
          end
          log_n++;
          m_cnt++;
        end
      end
      if (bus.req_valid && bus.req_ready) begin
        if (model_legal(int'(bus.req_opcode))) begin
          exp_addr.push_back(m_addr[7:0]);
          exp_data.push_back(model_enc(int'(bus.req_opcode), int'(bus.req_ra), int'(bus.req_rb),
                                       int'(bus.req_rc), int'(bus.req_imm)));
          m_addr = (m_addr + 1) % 256;
        end else begin
          m_ill = 1;
        end
      end
      if (start && !busy) begin
        m_sess = 1; m_cnt = 0; m_addr = int'(base_addr); m_ill = 0; m_wrap = 0; log_n = 0;
      end
      if (done) m_sess = 0;
      prev_stall = bus.imem_we && !bus.imem_ready;
      prev_addr  = bus.imem_addr;
      prev_data  = bus.imem_wdata;
      prev_done  = done;
    end
  end

  task automatic do_start(input logic [7:0] b);
    start = 1'b1; base_addr = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input int op, input int ra, input int rb, input int rc, input int imm, input bit last);
    int t = 0;
    bus.req_valid = 1'b1; bus.req_opcode = 6'(op); bus.req_ra = 5'(ra); bus.req_rb = 5'(rb);
    bus.req_rc = 5'(rc); bus.req_imm = 26'(imm); bus.req_last = last;
    do begin @(negedge clk); t++; end while (!bus.req_ready && t < 200);
    if (!bus.req_ready) chk("req_timeout", 0, 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_last = 1'b0;
  endtask

  task automatic wait_done();
    int c0 = done_cnt;
    int t = 0;
    while (done_cnt == c0 && t < 500) begin @(negedge clk); t++; end
    if (done_cnt == c0) chk("done_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    bus.req_valid = 0; bus.req_opcode = 0; bus.req_ra = 0; bus.req_rb = 0;
    bus.req_rc = 0; bus.req_imm = 0; bus.req_last = 0; bus.imem_ready = 1;
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: single ADD
    do_start(8'h10);
    send(6'h00, 3, 1, 2, 0, 1);
    wait_done();
    chk("t1_count", wr_count, 1);
    chk("t1_addr", log_addr[0], 8'h10);
    chk("t1_data", log_data[0], 32'h00611000);

    // 2: LDW, BEQ, JUMP
    do_start(8'h00);
    send(6'h11, 4, 5, 0, 'h10, 0);
    send(6'h30, 1, 2, 0, 'hFFFC, 0);
    send(6'h31, 0, 0, 0, 'h40, 1);
    wait_done();
    chk("t2_count", wr_count, 3);
    chk("t2_d0", log_data[0], 32'h44850010);
    chk("t2_d1", log_data[1], 32'hC022FFFC);
    chk("t2_d2", log_data[2], 32'hC4000040);
    chk("t2_a2", log_addr[2], 8'h02);

    // 3: back-pressure, FIFO full, start ignored while busy
    do_start(8'h20);
    bus.imem_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(6'h00, i, 0, 0, 0, 0);
    @(negedge clk);
    chk("t3_full_blocks", bus.req_ready, 0);
    @(posedge clk); #1;
    do_start(8'h80);
    fork
      begin
        send(6'h00, 5, 0, 0, 0, 0);
        send(6'h00, 6, 0, 0, 0, 1);
      end
      begin
        repeat (4) @(posedge clk); #1;
        bus.imem_ready = 1'b1;
      end
    join
    wait_done();
    chk("t3_count", wr_count, 6);
    for (int i = 0; i < 6; i++) begin
      chk("t3_addr", log_addr[i], 8'h20 + 8'(i));
      chk("t3_data", log_data[i], 32'h00200000 * (i + 1));
    end

    // 4: illegal opcode mid-stream
    do_start(8'h40);
    send(6'h00, 1, 0, 0, 0, 0);
    send(6'h3F, 7, 7, 7, 0, 0);
    send(6'h00, 2, 0, 0, 0, 1);
    wait_done();
    chk("t4_count", wr_count, 2);
    chk("t4_err_illegal", err_illegal, 1);
    chk("t4_next_addr", log_addr[1], 8'h41);
    chk("t4_next_data", log_data[1], 32'h00400000);

    // 5: address wrap, start clears err_illegal
    do_start(8'hFE);
    @(negedge clk);
    chk("t5_ill_cleared", err_illegal, 0);
    @(posedge clk); #1;
    send(6'h00, 1, 0, 0, 0, 0);
    send(6'h00, 2, 0, 0, 0, 0);
    send(6'h00, 3, 0, 0, 0, 1);
    wait_done();
    chk("t5_a0", log_addr[0], 8'hFE);
    chk("t5_a1", log_addr[1], 8'hFF);
    chk("t5_a2", log_addr[2], 8'h00);
    chk("t5_err_wrap", err_wrap, 1);

    // 6: reset with buffered words
    do_start(8'h30);
    bus.imem_ready = 1'b0;
    for (int i = 1; i <= 3; i++) send(6'h00, i, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_we", bus.imem_we, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_addr", bus.imem_addr, 0);
    chk("t6_rst_count", wr_count, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.imem_ready = 1'b1;
    repeat (10) @(posedge clk); #1;
    chk("t6_idle_busy", busy, 0);
    chk("t6_idle_we", bus.imem_we, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
